// File: rtl/apb3_req_arbiter_pkg.sv
// Shared types and constants for the APB3 requester arbiter.
// The transfer-phase encoding here is also used by the top-level sequencer.
package apb3_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Index width for an n-entry one-hot vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb3_req_arbiter_rr_arbiter.sv
// Combinational round-robin next-grant: searches from i_last+1, wrapping modulo N.
// Generic enough to be reused for DMA-channel arbitration.
module rr_arbiter
    import apb3_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt_oh,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_any
);

    // Walk candidates from farthest to nearest so the nearest pending request wins.
    always_comb begin
        logic [IW-1:0] v_idx;
        int            v_cand;
        o_gnt_oh  = {N{1'b0}};
        o_gnt_idx = {IW{1'b0}};
        o_any     = 1'b0;
        v_idx     = {IW{1'b0}};
        v_cand    = 0;
        for (int off = N; off >= 1; off--) begin
            v_cand = (int'(i_last) + off) % N;
            v_idx  = IW'(v_cand);
            if (i_req[v_idx]) begin
                o_gnt_oh        = {N{1'b0}};
                o_gnt_oh[v_idx] = 1'b1;
                o_gnt_idx       = v_idx;
                o_any           = 1'b1;
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/apb3_req_arbiter.sv
// Shares one APB3 slave port between NUM_REQ requesters with round-robin grant.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb3_req_arbiter
    import apb3_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic [ADDR_WIDTH-1:0]          PADDR,
    output logic                           PSEL,
    output logic                           PENABLE,
    output logic                           PWRITE,
    output logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic                           PREADY,
    input  logic [DATA_WIDTH-1:0]          PRDATA,
    input  logic                           PSLVERROR
);

    localparam int            IW        = idx_width(NUM_REQ);
    localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

`ifdef APB_TIMEOUT_EN
    localparam int                    CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] ABORT_RDATA = DATA_WIDTH'(TIMEOUT_RDATA);
    logic [CNT_W-1:0]                 r_wdog;
`endif

    apb_state_t              r_state;
    logic [IW-1:0]           r_last;
    logic [NUM_REQ-1:0]      r_gnt_oh;
    logic [NUM_REQ-1:0]      r_req_ready;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic                    r_pwrite;
    logic                    r_psel;
    logic                    r_penable;

    logic [NUM_REQ-1:0]      w_gnt_oh;
    logic [IW-1:0]           w_gnt_idx;
    logic                    w_any;
    logic [ADDR_WIDTH-1:0]   w_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   w_wdata [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .i_req     (req_valid),
        .i_last    (r_last),
        .o_gnt_oh  (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // Transfer sequencer: grant in IDLE, then SETUP, ACCESS (until PREADY), RESP pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last      <= LAST_INIT;
            r_gnt_oh    <= {NUM_REQ{1'b0}};
            r_req_ready <= {NUM_REQ{1'b0}};
            r_rsp_valid <= {NUM_REQ{1'b0}};
            r_rsp_rdata <= {DATA_WIDTH{1'b0}};
            r_rsp_err   <= 1'b0;
            r_paddr     <= {ADDR_WIDTH{1'b0}};
            r_pwdata    <= {DATA_WIDTH{1'b0}};
            r_pwrite    <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_wdog      <= {CNT_W{1'b0}};
`endif
        end else begin
            r_req_ready <= {NUM_REQ{1'b0}};
            r_rsp_valid <= {NUM_REQ{1'b0}};
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_req_ready <= w_gnt_oh;
                        r_gnt_oh    <= w_gnt_oh;
                        r_last      <= w_gnt_idx;
                        r_paddr     <= w_addr[w_gnt_idx];
                        r_pwdata    <= w_wdata[w_gnt_idx];
                        r_pwrite    <= req_write[w_gnt_idx];
                        r_psel      <= 1'b1;
`ifdef APB_TIMEOUT_EN
                        r_wdog      <= {CNT_W{1'b0}};
`endif
                        r_state     <= SETUP;
                    end else begin
                        r_psel <= 1'b0;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    // A late PREADY on the watchdog's final cycle still completes normally.
                    if (PREADY) begin
                        r_rsp_rdata <= r_pwrite ? {DATA_WIDTH{1'b0}} : PRDATA;
                        r_rsp_err   <= PSLVERROR;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (r_wdog == CNT_LAST) begin
                        r_rsp_rdata <= ABORT_RDATA;
                        r_rsp_err   <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= RESP;
                    end else begin
                        r_wdog <= r_wdog + CNT_W'(1);
                    end
`else
                    else begin
                        r_state <= ACCESS;
                    end
`endif
                end
                RESP: begin
                    r_rsp_valid <= r_gnt_oh;
                    r_state     <= IDLE;
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign PADDR     = r_paddr;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb3_req_arbiter.sv
// Bench for apb3_req_arbiter: directed scenarios plus randomized traffic against a
// cycle-level transaction model. Define APB_TIMEOUT_EN to include the watchdog cases.
module tb_apb3_req_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int TO   = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid, req_write, req_ready, rsp_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [DW-1:0]        rsp_rdata, PWDATA, PRDATA;
    logic                 rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERROR;
    logic [AW-1:0]        PADDR;

    apb3_req_arbiter #(
        .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERROR(PSLVERROR)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // requester-side state
    bit            rq_on  [NREQ];
    bit            rq_rep [NREQ];
    logic          rq_w   [NREQ];
    logic [AW-1:0] rq_a   [NREQ];
    logic [DW-1:0] rq_d   [NREQ];
    bit            rnd_en;

    // slave behaviour
    int            sl_mode;
    int            sl_wait;
    int            sl_cnt;
    logic [DW-1:0] sl_rdata;
    logic          sl_err;

    // reference model
    int            m_phase;   // 0 bus free, 1 setup cycle, 2 access
    int            m_last, m_free, m_rsp_at, m_gidx, m_acc;
    logic          m_gw;
    logic [AW-1:0] m_ga;
    logic [DW-1:0] m_gd;
    logic [DW-1:0] m_rdata;
    logic          m_err;
    int            grant_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_last   = NREQ - 1;
        m_free   = 0;
        m_rsp_at = -1;
        m_gidx   = 0;
        m_acc    = 0;
        m_rdata  = '0;
        m_err    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rq_on[i]  = 1'b0;
            rq_rep[i] = 1'b0;
        end
    endtask

    task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq_on[i] = 1'b1;
        rq_w[i]  = w;
        rq_a[i]  = a;
        rq_d[i]  = d;
    endtask

    task automatic complete(input logic [DW-1:0] rd, input logic er);
        m_phase  = 0;
        m_rdata  = rd;
        m_err    = er;
        m_rsp_at = cyc + 1;
        m_free   = cyc + 2;
    endtask

    // Expectations for the cycle just clocked, from the transaction rules.
    task automatic model_check();
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rsp;
        int              w;
        exp_rdy = '0;
        exp_rsp = '0;
        if (m_rsp_at == cyc) exp_rsp[m_gidx] = 1'b1;
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) grant_q.push_back(i);
        case (m_phase)
            2: begin
                if (PREADY) begin
                    complete(m_gw ? '0 : PRDATA, PSLVERROR);
                end else begin
                    m_acc++;
`ifdef APB_TIMEOUT_EN
                    if (m_acc == TO) complete(32'hDEAD_BEEF, 1'b1);
`endif
                end
            end
            1: m_phase = 2;
            default: begin
                if (cyc >= m_free && req_valid != '0) begin
                    w = -1;
                    for (int off = 1; off <= NREQ; off++)
                        if (w < 0 && req_valid[(m_last + off) % NREQ]) w = (m_last + off) % NREQ;
                    exp_rdy[w] = 1'b1;
                    m_gidx  = w;
                    m_last  = w;
                    m_phase = 1;
                    m_acc   = 0;
                    m_gw    = rq_w[w];
                    m_ga    = rq_a[w];
                    m_gd    = rq_d[w];
                    rq_on[w] = 1'b0;
                end
            end
        endcase
        chk("req_ready", req_ready, exp_rdy);
        chk("rsp_valid", rsp_valid, exp_rsp);
        chk("psel", PSEL, m_phase != 0);
        chk("penable", PENABLE, m_phase == 2);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
        if (m_phase != 0) begin
            chk("paddr", PADDR, m_ga);
            chk("pwrite", PWRITE, m_gw);
            chk("pwdata", PWDATA, m_gd);
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (!rq_on[i] && (rq_rep[i] || (rnd_en && $urandom_range(0, 3) == 0))) begin
                rq_on[i] = 1'b1;
                rq_w[i]  = 1'($urandom);
                rq_a[i]  = AW'($urandom);
                rq_d[i]  = $urandom;
            end
            req_valid[i] = rq_on[i];
            if (rq_on[i]) begin
                req_write[i]               = rq_w[i];
                req_addr[i*AW +: AW]       = rq_a[i];
                req_wdata[i*DW +: DW]      = rq_d[i];
            end else begin
                req_write[i]               = 1'($urandom);
                req_addr[i*AW +: AW]       = AW'($urandom);
                req_wdata[i*DW +: DW]      = $urandom;
            end
        end
        case (sl_mode)
            0: begin
                PREADY    = 1'($urandom);
                PRDATA    = $urandom;
                PSLVERROR = ($urandom_range(0, 3) == 0);
            end
            1: begin
                PREADY = 1'b1; PRDATA = sl_rdata; PSLVERROR = sl_err;
            end
            2: begin
                if (PSEL && PENABLE) begin
                    PREADY = (sl_cnt >= sl_wait);
                    sl_cnt++;
                end else begin
                    PREADY = 1'b0;
                    sl_cnt = 0;
                end
                PRDATA = sl_rdata; PSLVERROR = sl_err;
            end
            default: begin
                PREADY = 1'b0; PRDATA = sl_rdata; PSLVERROR = sl_err;
            end
        endcase
        @(posedge clk);
        #1;
        cyc++;
        model_check();
    endtask

    task automatic wait_rsp(output int rc);
        rc = -1000;
        for (int k = 0; k < 60; k++) begin
            step();
            if (rsp_valid != '0) begin
                rc = cyc;
                break;
            end
        end
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 300; k++) begin
            idle = (m_phase == 0) && (m_rsp_at < cyc);
            for (int i = 0; i < NREQ; i++) if (rq_on[i]) idle = 1'b0;
            if (idle) break;
            step();
        end
        chk("drain_idle", idle, 1'b1);
    endtask

    initial begin
        int t0, rc;
        reset     = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PREADY = 1'b0; PRDATA = '0; PSLVERROR = 1'b0;
        rnd_en = 1'b0; sl_mode = 1; sl_wait = 0; sl_cnt = 0; sl_rdata = '0; sl_err = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_ready", req_ready, '0);
        chk("rst_rsp", rsp_valid, '0);
        chk("rst_rdata", rsp_rdata, '0);
        @(negedge clk);
        reset = 1'b0;

        // single write, zero wait-states
        issue(0, 1'b1, 12'h004, 32'h1);
        t0 = cyc;
        wait_rsp(rc);
        chk("lat_write", rc - t0, 4);
        chk("write_err", rsp_err, 1'b0);

        // read with three wait-states
        sl_mode = 2; sl_wait = 3; sl_rdata = 32'hABCD_5678;
        issue(1, 1'b0, 12'h040, 32'h0);
        t0 = cyc;
        wait_rsp(rc);
        chk("lat_wait3", rc - t0, 7);
        chk("rd_data", rsp_rdata, 32'hABCD_5678);

        // two requesters asserting continuously
        sl_mode = 1; sl_rdata = 32'h5555_AAAA;
        grant_q.delete();
        rq_rep[0] = 1'b1; rq_rep[1] = 1'b1;
        for (int k = 0; k < 60 && grant_q.size() < 4; k++) step();
        rq_rep[0] = 1'b0; rq_rep[1] = 1'b0;
        for (int k = 0; k < 4; k++)
            chk("rr_order", (grant_q.size() > k) ? grant_q[k] : -1, k % 2);
        drain();

        // slave error then clean transfer
        sl_err = 1'b1; sl_rdata = 32'h0BAD_0BAD;
        issue(0, 1'b0, 12'h0FC, 32'h0);
        wait_rsp(rc);
        chk("err_set", rsp_err, 1'b1);
        sl_err = 1'b0;
        issue(1, 1'b0, 12'h010, 32'h0);
        wait_rsp(rc);
        chk("err_clr", rsp_err, 1'b0);

`ifdef APB_TIMEOUT_EN
        sl_mode = 3; sl_rdata = 32'h1111_2222;
        issue(0, 1'b0, 12'h020, 32'h0);
        t0 = cyc;
        wait_rsp(rc);
        chk("to_lat", rc - t0, 4 + TO - 1);
        chk("to_err", rsp_err, 1'b1);
        chk("to_rdata", rsp_rdata, 32'hDEAD_BEEF);
        sl_mode = 2; sl_wait = TO - 1;
        issue(1, 1'b0, 12'h024, 32'h0);
        t0 = cyc;
        wait_rsp(rc);
        chk("to_edge_lat", rc - t0, 4 + TO - 1);
        chk("to_edge_err", rsp_err, 1'b0);
        chk("to_edge_rdata", rsp_rdata, 32'h1111_2222);
`endif

        // randomized traffic
        sl_mode = 0;
        rnd_en  = 1'b1;
        repeat (500) step();
        rnd_en  = 1'b0;
        drain();

        // reset while in ACCESS
        sl_mode = 2; sl_wait = 6; sl_rdata = 32'h7777_0000;
        issue(1, 1'b1, 12'h100, 32'h42);
        for (int k = 0; k < 20 && m_phase != 2; k++) step();
        chk("pre_rst_access", PENABLE, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_psel", PSEL, 1'b0);
        chk("midrst_penable", PENABLE, 1'b0);
        chk("midrst_rsp", rsp_valid, '0);
        model_reset();
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        sl_mode = 1;
        issue(0, 1'b0, 12'h008, 32'h0);
        issue(1, 1'b0, 12'h00C, 32'h0);
        step();
        chk("rst_first_grant", req_ready, 3'b001);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
